// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache victim-way selector.
// Holds the selector FSM state encoding and the round-robin wrap function.
package cache_pkg;

   typedef enum logic {
      VS_IDLE = 1'b0,
      VS_HOLD = 1'b1
   } victim_state_e;

   // Next round-robin position; wraps at ways-1 rather than at a power of two.
   function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned ways);
      return (idx == ways - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/first_one_n.sv
// Lowest-set-bit encoder: returns the index of the lowest 1 in vec_i
// and a flag telling whether any bit is set.
module first_one_n #(
   parameter  int w_p   = 4,
   localparam int iw_lp = (w_p > 1) ? $clog2(w_p) : 1
) (
   input  logic [w_p-1:0]   vec_i,
   output logic [iw_lp-1:0] idx_o,
   output logic             any_o
);

   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = w_p - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = iw_lp'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cache_victim_select.sv
// Victim-way selector: lowest available way for fill, else round-robin eviction.
// Optional way locking is compiled in with CACHE_VICTIM_LOCK_EN.
module cache_victim_select
   import cache_pkg::*;
#(
   parameter  int ways_p      = 4,
   parameter  bit avail_bit_p = 1'b1,
   localparam int idx_w_lp    = $clog2(ways_p)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_v_i,
   input  logic [ways_p-1:0]   avail_i,
   input  logic [ways_p-1:0]   lock_i,
   output logic                ready_o,
   output logic                victim_v_o,
   output logic [idx_w_lp-1:0] victim_o,
   output logic                victim_fill_o,
   output logic                victim_none_o,
   input  logic                victim_yumi_i,
   output victim_state_e       state_o
);

   // Handshake: a request is taken when req_v_i & ready_o at a rising edge; a
   // result is held on victim_v_o until victim_yumi_i is seen at a rising edge.

   localparam logic [idx_w_lp:0] ways_c = (idx_w_lp + 1)'(ways_p);

   victim_state_e         state_q;
   logic [idx_w_lp-1:0]   rr_q;
   logic [ways_p-1:0]     elig, free, rot;
   logic [idx_w_lp-1:0]   free_idx, rot_idx, evict_idx, sel_idx;
   logic                  free_any, rot_any, sel_fill, sel_none;
   logic [idx_w_lp:0]     rot_sum;

`ifdef CACHE_VICTIM_LOCK_EN
   assign elig = ~lock_i;
`else
   logic unused_lock;
   assign unused_lock = ^lock_i;
   assign elig        = '1;
`endif

   always_comb begin
      free = '0;
      for (int i = 0; i < ways_p; i++) begin
         free[i] = elig[i] & (avail_i[i] == avail_bit_p);
      end
   end

   // Rotate so bit 0 of rot is way rr_q; the first eligible bit gives the eviction offset.
   assign rot = ways_p'({elig, elig} >> rr_q);

   first_one_n #(.w_p(ways_p)) u_free_enc (
      .vec_i (free),
      .idx_o (free_idx),
      .any_o (free_any)
   );

   first_one_n #(.w_p(ways_p)) u_rot_enc (
      .vec_i (rot),
      .idx_o (rot_idx),
      .any_o (rot_any)
   );

   assign rot_sum   = {1'b0, rr_q} + {1'b0, rot_idx};
   assign evict_idx = (rot_sum >= ways_c) ? idx_w_lp'(rot_sum - ways_c) : rot_sum[idx_w_lp-1:0];

   always_comb begin
      sel_idx  = '0;
      sel_fill = 1'b0;
      sel_none = 1'b0;
      if (free_any) begin
         sel_idx  = free_idx;
         sel_fill = 1'b1;
      end else if (rot_any) begin
         sel_idx  = evict_idx;
      end else begin
         sel_none = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= VS_IDLE;
         rr_q          <= '0;
         ready_o       <= 1'b1;
         victim_v_o    <= 1'b0;
         victim_o      <= '0;
         victim_fill_o <= 1'b0;
         victim_none_o <= 1'b0;
      end else begin
         case (state_q)
            VS_IDLE: begin
               if (req_v_i) begin
                  state_q       <= VS_HOLD;
                  ready_o       <= 1'b0;
                  victim_v_o    <= 1'b1;
                  victim_o      <= sel_idx;
                  victim_fill_o <= sel_fill;
                  victim_none_o <= sel_none;
               end
            end
            VS_HOLD: begin
               if (victim_yumi_i) begin
                  state_q    <= VS_IDLE;
                  ready_o    <= 1'b1;
                  victim_v_o <= 1'b0;
                  if (!victim_fill_o && !victim_none_o) begin
                     rr_q <= idx_w_lp'(rr_wrap(32'(victim_o), ways_p));
                  end
               end
            end
            default: state_q <= VS_IDLE;
         endcase
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_cache_victim_select.sv
// Bench for cache_victim_select: three instances (4-way, 4-way inverted avail, 3-way)
// share one stimulus stream and are checked against a way-scan reference model.
module tb_cache_victim_select;
   import cache_pkg::*;

`ifdef CACHE_VICTIM_LOCK_EN
   localparam bit lock_en = 1'b1;
`else
   localparam bit lock_en = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_v = 1'b0;
   logic yumi = 1'b0;
   logic [3:0] avail = '0;
   logic [3:0] lock = '0;

   logic rdy[3], v_o[3], fill_o[3], none_o[3];
   logic [1:0] vic[3];
   victim_state_e st[3];

   int n_cmp = 0;
   int n_err = 0;
   int ways_k[3] = '{4, 4, 3};
   bit abit_k[3] = '{1'b1, 1'b0, 1'b1};
   int rr_m[3] = '{0, 0, 0};
   int exp_v[3];
   bit exp_f[3], exp_n[3];
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   cache_victim_select #(.ways_p(4), .avail_bit_p(1'b1)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .req_v_i(req_v), .avail_i(avail), .lock_i(lock),
      .ready_o(rdy[0]), .victim_v_o(v_o[0]), .victim_o(vic[0]), .victim_fill_o(fill_o[0]),
      .victim_none_o(none_o[0]), .victim_yumi_i(yumi), .state_o(st[0]));

   cache_victim_select #(.ways_p(4), .avail_bit_p(1'b0)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .req_v_i(req_v), .avail_i(avail), .lock_i(lock),
      .ready_o(rdy[1]), .victim_v_o(v_o[1]), .victim_o(vic[1]), .victim_fill_o(fill_o[1]),
      .victim_none_o(none_o[1]), .victim_yumi_i(yumi), .state_o(st[1]));

   cache_victim_select #(.ways_p(3), .avail_bit_p(1'b1)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .req_v_i(req_v), .avail_i(avail[2:0]), .lock_i(lock[2:0]),
      .ready_o(rdy[2]), .victim_v_o(v_o[2]), .victim_o(vic[2]), .victim_fill_o(fill_o[2]),
      .victim_none_o(none_o[2]), .victim_yumi_i(yumi), .state_o(st[2]));

   // Reference: first free eligible way, else first eligible way scanning up from rr.
   function automatic void predict(input int k, input logic [3:0] av, input logic [3:0] lk,
                                   output int v, output bit f, output bit n);
      int w;
      int j;
      bit found;
      w = ways_k[k];
      v = 0; f = 1'b0; n = 1'b0; found = 1'b0;
      for (int i = 0; i < w; i++) begin
         if (!found && !(lock_en && lk[i]) && av[i] == abit_k[k]) begin
            v = i; f = 1'b1; found = 1'b1;
         end
      end
      for (int s = 0; s < w; s++) begin
         j = (rr_m[k] + s) % w;
         if (!found && !(lock_en && lk[j])) begin
            v = j; found = 1'b1;
         end
      end
      if (!found) n = 1'b1;
   endfunction

   task automatic accept(input logic [3:0] av, input logic [3:0] lk);
      int n;
      n = 0;
      while (rdy[0] !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 20) begin
         n_cmp++; n_err++;
         $display("FAIL accept_wait ready=%b required 1 within 20 cycles", rdy[0]);
      end
      for (int k = 0; k < 3; k++) predict(k, av, lk, exp_v[k], exp_f[k], exp_n[k]);
      req_v = 1'b1; avail = av; lock = lk;
      @(posedge clk); #1;
      req_v = 1'b0;
   endtask

   task automatic consume();
      yumi = 1'b1;
      @(posedge clk); #1;
      yumi = 1'b0;
      for (int k = 0; k < 3; k++)
         if (!exp_f[k] && !exp_n[k]) rr_m[k] = (exp_v[k] + 1) % ways_k[k];
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) rr_m[k] = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (rdy[k] !== 1'b1 || v_o[k] !== 1'b0 || vic[k] !== 2'd0 || fill_o[k] !== 1'b0 ||
             none_o[k] !== 1'b0 || st[k] !== VS_IDLE) begin
            n_err++;
            $display("FAIL reset dut%0d got rdy=%b v=%b vic=%0d f=%b n=%b st=%0d required 1 0 0 0 0 0",
                     k, rdy[k], v_o[k], vic[k], fill_o[k], none_o[k], st[k]);
         end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      logic [3:0] pats[3] = '{4'b0100, 4'b0011, 4'b1010};
      for (int p = 0; p < 3; p++) begin
         accept(pats[p], 4'b0000);
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (v_o[k] !== 1'b1 || rdy[k] !== 1'b0 || vic[k] !== exp_v[k][1:0] ||
                fill_o[k] !== exp_f[k] || none_o[k] !== exp_n[k]) begin
               n_err++;
               $display("FAIL fill dut%0d pat=%b got v=%b vic=%0d f=%b n=%b required v=1 vic=%0d f=%b n=%b",
                        k, pats[p], v_o[k], vic[k], fill_o[k], none_o[k], exp_v[k], exp_f[k], exp_n[k]);
            end
         end
         n_cmp++;
         if (p == 0 && (vic[0] !== 2'd2 || fill_o[0] !== 1'b1)) begin
            n_err++;
            $display("FAIL fill_0100 got vic=%0d f=%b required vic=2 f=1", vic[0], fill_o[0]);
         end
         if (p == 1 && (vic[1] !== 2'd2 || fill_o[1] !== 1'b1)) begin
            n_err++;
            $display("FAIL fill_inv_0011 got vic=%0d f=%b required vic=2 f=1", vic[1], fill_o[1]);
         end
         consume();
      end
   endtask

   task automatic test_wrap();
      int want3[4] = '{0, 1, 2, 0};
      for (int p = 0; p < 4; p++) begin
         accept(4'b0000, 4'b0000);
         n_cmp++;
         if (vic[2] !== want3[p][1:0] || fill_o[2] !== 1'b0 || vic[0] !== 2'(p)) begin
            n_err++;
            $display("FAIL wrap step%0d got vic3=%0d f3=%b vic4=%0d required vic3=%0d f3=0 vic4=%0d",
                     p, vic[2], fill_o[2], vic[0], want3[p], p);
         end
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (vic[k] !== exp_v[k][1:0] || fill_o[k] !== exp_f[k] || none_o[k] !== exp_n[k]) begin
               n_err++;
               $display("FAIL wrap_model dut%0d got vic=%0d f=%b n=%b required vic=%0d f=%b n=%b",
                        k, vic[k], fill_o[k], none_o[k], exp_v[k], exp_f[k], exp_n[k]);
            end
         end
         consume();
      end
   endtask

   task automatic test_reset_mid_hold();
      apply_reset();
      accept(4'b0000, 4'b0000); consume();
      accept(4'b0000, 4'b0000); consume();
      accept(4'b0000, 4'b0000);
      n_cmp++;
      if (vic[0] !== 2'd2 || v_o[0] !== 1'b1) begin
         n_err++;
         $display("FAIL third_evict got v=%b vic=%0d required v=1 vic=2", v_o[0], vic[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (v_o[k] !== 1'b0 || rdy[k] !== 1'b1 || vic[k] !== 2'd0 || st[k] !== VS_IDLE) begin
            n_err++;
            $display("FAIL async_reset dut%0d got v=%b rdy=%b vic=%0d st=%0d required 0 1 0 0",
                     k, v_o[k], rdy[k], vic[k], st[k]);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) rr_m[k] = 0;
      accept(4'b0000, 4'b0000);
      n_cmp++;
      if (vic[0] !== 2'd0 || fill_o[0] !== 1'b0 || v_o[0] !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset_evict got v=%b vic=%0d f=%b required v=1 vic=0 f=0",
                  v_o[0], vic[0], fill_o[0]);
      end
      consume();
   endtask

   task automatic test_hold();
      accept(4'b0000, 4'b0000);
      for (int c = 0; c < 5; c++) begin
         req_v = ~req_v;
         avail = 4'($urandom_range(0, 15));
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (v_o[k] !== 1'b1 || rdy[k] !== 1'b0 || vic[k] !== exp_v[k][1:0] || fill_o[k] !== exp_f[k]) begin
               n_err++;
               $display("FAIL hold dut%0d cyc%0d got v=%b rdy=%b vic=%0d f=%b required v=1 rdy=0 vic=%0d f=%b",
                        k, c, v_o[k], rdy[k], vic[k], fill_o[k], exp_v[k], exp_f[k]);
            end
         end
      end
      req_v = 1'b0;
      consume();
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (v_o[k] !== 1'b0 || rdy[k] !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release dut%0d got v=%b rdy=%b required v=0 rdy=1", k, v_o[k], rdy[k]);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] av, lk, got, want;
      for (int t = 0; t < 40; t++) begin
         av = 4'($urandom_range(0, 15)) & ($urandom_range(0, 1) ? 4'hF : 4'h0);
         lk = 4'($urandom_range(0, 15));
         accept(av, lk);
         exp_q.push_back({exp_n[0], exp_f[0], exp_v[0][1:0]});
         for (int c = $urandom_range(0, 3); c > 0; c--) begin
            req_v = 1'($urandom_range(0, 1));
            avail = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
         end
         req_v = 1'b0;
         want = exp_q.pop_front();
         got = {none_o[0], fill_o[0], vic[0]};
         n_cmp++;
         if (got !== want || v_o[0] !== 1'b1) begin
            n_err++;
            $display("FAIL random t%0d av=%b lk=%b got v=%b {n,f,vic}=%b required v=1 %b",
                     t, av, lk, v_o[0], got, want);
         end
         for (int k = 1; k < 3; k++) begin
            n_cmp++;
            if (vic[k] !== exp_v[k][1:0] || fill_o[k] !== exp_f[k] || none_o[k] !== exp_n[k]) begin
               n_err++;
               $display("FAIL random t%0d dut%0d got vic=%0d f=%b n=%b required vic=%0d f=%b n=%b",
                        t, k, vic[k], fill_o[k], none_o[k], exp_v[k], exp_f[k], exp_n[k]);
            end
         end
         consume();
         if ($urandom_range(0, 2) == 0) begin
            yumi = 1'b1;
            @(posedge clk); #1;
            yumi = 1'b0;
            n_cmp++;
            if (v_o[0] !== 1'b0 || rdy[0] !== 1'b1) begin
               n_err++;
               $display("FAIL stray_yumi got v=%b rdy=%b required v=0 rdy=1", v_o[0], rdy[0]);
            end
         end
      end
   endtask

`ifdef CACHE_VICTIM_LOCK_EN
   task automatic test_lock();
      logic [3:0] lks[5] = '{4'b0000, 4'b0110, 4'b0000, 4'b1111, 4'b0000};
      int want[5] = '{0, 3, 0, 0, 1};
      bit want_n[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      apply_reset();
      for (int p = 0; p < 5; p++) begin
         accept(4'b0000, lks[p]);
         n_cmp++;
         if (vic[0] !== want[p][1:0] || none_o[0] !== want_n[p] || fill_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL lock step%0d got vic=%0d n=%b f=%b required vic=%0d n=%b f=0",
                     p, vic[0], none_o[0], fill_o[0], want[p], want_n[p]);
         end
         for (int k = 1; k < 3; k++) begin
            n_cmp++;
            if (vic[k] !== exp_v[k][1:0] || fill_o[k] !== exp_f[k] || none_o[k] !== exp_n[k]) begin
               n_err++;
               $display("FAIL lock_model step%0d dut%0d got vic=%0d f=%b n=%b required vic=%0d f=%b n=%b",
                        p, k, vic[k], fill_o[k], none_o[k], exp_v[k], exp_f[k], exp_n[k]);
            end
         end
         consume();
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill();
      test_wrap();
      test_reset_mid_hold();
      test_hold();
      test_random();
`ifdef CACHE_VICTIM_LOCK_EN
      test_lock();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
